// File: rtl/axi_mem_slv.sv
// axi_mem_slv: AXI4 memory slave with independent write/read FSMs over a small register array.
// Optional macro AXI_MEM_SLV_ADDR_CHECK_EN: out-of-range beats return SLVERR instead of aliasing.
module axi_mem_slv #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned NumWords  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]             ar_len_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [IdWidth-1:0]     r_id_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned MemAw     = $clog2(NumWords);
`ifdef AXI_MEM_SLV_ADDR_CHECK_EN
    localparam int unsigned IdxW      = AddrWidth - OffW;
`else
    localparam int unsigned IdxW      = MemAw;
`endif
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA} rstate_e;

    logic [DataWidth-1:0] r_mem [NumWords];

    wstate_e              r_wstate;
    logic [IdWidth-1:0]   r_wid;
    logic [IdxW-1:0]      r_widx;
    logic [8:0]           r_wcnt;
    logic                 r_werr;

    rstate_e              r_rstate;
    logic [IdxW-1:0]      r_ridx;
    logic [8:0]           r_rcnt;

    logic [IdxW-1:0]      w_aw_idx;
    logic [IdxW-1:0]      w_ar_idx;
    logic [IdxW-1:0]      w_rnext_idx;
    logic                 w_w_oor;
    logic                 w_r_oor;
    logic                 w_ar_oor;
    logic                 w_rnext_oor;
    logic                 w_werr_nxt;
    logic                 w_unused;

    assign w_aw_idx    = aw_addr_i[OffW +: IdxW];
    assign w_ar_idx    = ar_addr_i[OffW +: IdxW];
    assign w_rnext_idx = r_ridx + IdxW'(1);

`ifdef AXI_MEM_SLV_ADDR_CHECK_EN
    assign w_w_oor     = (r_widx >= IdxW'(NumWords));
    assign w_r_oor     = (r_ridx >= IdxW'(NumWords));
    assign w_ar_oor    = (w_ar_idx >= IdxW'(NumWords));
    assign w_rnext_oor = (w_rnext_idx >= IdxW'(NumWords));
    assign w_unused    = ^{aw_addr_i[OffW-1:0], ar_addr_i[OffW-1:0]};
`else
    // Without the check the index simply wraps, so high address bits are don't-care.
    assign w_w_oor     = 1'b0;
    assign w_r_oor     = 1'b0;
    assign w_ar_oor    = 1'b0;
    assign w_rnext_oor = 1'b0;
    assign w_unused    = ^{aw_addr_i[OffW-1:0], ar_addr_i[OffW-1:0],
                           aw_addr_i[AddrWidth-1:OffW+MemAw], ar_addr_i[AddrWidth-1:OffW+MemAw]};
`endif

    // Sticky error includes this beat's last-flag mismatch and range violation.
    assign w_werr_nxt = r_werr | (w_last_i != (r_wcnt == 9'd1)) | w_w_oor;

    assign r_data_o = w_r_oor ? '0 : r_mem[r_ridx[MemAw-1:0]];

    // Write channel FSM; also owns the memory array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wstate   <= W_IDLE;
            aw_ready_o <= 1'b1;
            w_ready_o  <= 1'b0;
            b_valid_o  <= 1'b0;
            b_id_o     <= '0;
            b_resp_o   <= RespOkay;
            r_wid      <= '0;
            r_widx     <= '0;
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
            for (int unsigned i = 0; i < NumWords; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (aw_valid_i) begin
                        r_wid      <= aw_id_i;
                        r_widx     <= w_aw_idx;
                        r_wcnt     <= 9'(aw_len_i) + 9'd1;
                        aw_ready_o <= 1'b0;
                        w_ready_o  <= 1'b1;
                        r_wstate   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_valid_i) begin
                        if (!w_w_oor) begin
                            for (int unsigned b = 0; b < StrbWidth; b++) begin
                                if (w_strb_i[b]) begin
                                    r_mem[r_widx[MemAw-1:0]][b*8 +: 8] <= w_data_i[b*8 +: 8];
                                end
                            end
                        end
                        r_widx <= r_widx + IdxW'(1);
                        r_wcnt <= r_wcnt - 9'd1;
                        r_werr <= w_werr_nxt;
                        if (r_wcnt == 9'd1) begin
                            w_ready_o <= 1'b0;
                            b_valid_o <= 1'b1;
                            b_id_o    <= r_wid;
                            b_resp_o  <= w_werr_nxt ? RespSlvErr : RespOkay;
                            r_wstate  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_o  <= 1'b0;
                        aw_ready_o <= 1'b1;
                        r_werr     <= 1'b0;
                        r_wstate   <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; r_resp_o/r_last_o are precomputed for the beat being presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rstate   <= R_IDLE;
            ar_ready_o <= 1'b1;
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_id_o     <= '0;
            r_resp_o   <= RespOkay;
            r_ridx     <= '0;
            r_rcnt     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (ar_valid_i) begin
                        r_id_o     <= ar_id_i;
                        r_ridx     <= w_ar_idx;
                        r_rcnt     <= 9'(ar_len_i) + 9'd1;
                        r_last_o   <= (ar_len_i == 8'd0);
                        r_resp_o   <= w_ar_oor ? RespSlvErr : RespOkay;
                        ar_ready_o <= 1'b0;
                        r_valid_o  <= 1'b1;
                        r_rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        r_ridx <= w_rnext_idx;
                        r_rcnt <= r_rcnt - 9'd1;
                        if (r_rcnt == 9'd1) begin
                            r_valid_o  <= 1'b0;
                            r_last_o   <= 1'b0;
                            ar_ready_o <= 1'b1;
                            r_rstate   <= R_IDLE;
                        end else begin
                            r_last_o <= (r_rcnt == 9'd2);
                            r_resp_o <= w_rnext_oor ? RespSlvErr : RespOkay;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slv.sv
// tb_axi_mem_slv: directed and random AXI bursts against a word-array reference model.
module tb_axi_mem_slv;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned IW  = 4;
    localparam int unsigned NW  = 16;
    localparam int unsigned MAW = $clog2(NW);
`ifdef AXI_MEM_SLV_ADDR_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic          b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [IW-1:0] aw_id, b_id, ar_id, r_id;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [7:0]    aw_len, ar_len, w_strb;
    logic [DW-1:0] w_data, r_data;
    logic [1:0]    b_resp, r_resp;

    axi_mem_slv #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .NumWords(NW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model_mem [NW];
    logic [DW-1:0] wdata [256];
    logic [7:0]    wstrb [256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 when the beat is rejected as out of range.
    function automatic bit model_write(input int unsigned idx, input logic [DW-1:0] d, input logic [7:0] s);
        if (ChkEn && idx >= NW) return 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) model_mem[MAW'(idx % NW)][b*8 +: 8] = d[b*8 +: 8];
        end
        return 1'b0;
    endfunction

    task automatic model_read(input int unsigned idx, output logic [DW-1:0] d, output logic [1:0] rs);
        if (ChkEn && idx >= NW) begin
            d = '0; rs = 2'b10;
        end else begin
            d = model_mem[MAW'(idx % NW)]; rs = 2'b00;
        end
    endtask

    task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input int bad_beat, input int b_stall);
        int unsigned idx;
        bit          err;
        logic [1:0]  exp_resp;
        idx = addr >> 3;
        err = (bad_beat >= 0);
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = 8'(len);
        check("aw_ready_idle", 64'(aw_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            check("w_ready_data", 64'(w_ready), 64'd1);
            check("aw_ready_busy", 64'(aw_ready), 64'd0);
            w_valid = 1'b1; w_data = wdata[k]; w_strb = wstrb[k];
            w_last = ((k == len) != (k == bad_beat));
            @(posedge clk); #1;
            if (model_write(idx + 32'(k), wdata[k], wstrb[k])) err = 1'b1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
        check("b_valid_rise", 64'(b_valid), 64'd1);
        check("b_id", 64'(b_id), 64'(id));
        check("b_resp", 64'(b_resp), 64'(exp_resp));
        check("w_ready_done", 64'(w_ready), 64'd0);
        b_ready = 1'b0;
        for (int c = 0; c < b_stall; c++) begin
            @(posedge clk); #1;
            check("b_valid_hold", 64'(b_valid), 64'd1);
            check("b_resp_hold", 64'(b_resp), 64'(exp_resp));
            check("b_id_hold", 64'(b_id), 64'(id));
            check("aw_ready_bstall", 64'(aw_ready), 64'd0);
        end
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        check("b_valid_fall", 64'(b_valid), 64'd0);
        check("aw_ready_back", 64'(aw_ready), 64'd1);
    endtask

    task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input int stall_beat, input int stall);
        int unsigned   idx;
        logic [DW-1:0] d;
        logic [1:0]    rs;
        idx = addr >> 3;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
        check("ar_ready_idle", 64'(ar_ready), 64'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            model_read(idx + 32'(k), d, rs);
            if (k == stall_beat) begin
                for (int c = 0; c < stall; c++) begin
                    r_ready = 1'b0;
                    check("r_valid_hold", 64'(r_valid), 64'd1);
                    check("r_data_hold", r_data, d);
                    check("r_last_hold", 64'(r_last), 64'(k == len));
                    check("ar_ready_rstall", 64'(ar_ready), 64'd0);
                    @(posedge clk); #1;
                end
            end
            check("r_valid", 64'(r_valid), 64'd1);
            check("r_data", r_data, d);
            check("r_resp", 64'(r_resp), 64'(rs));
            check("r_last", 64'(r_last), 64'(k == len));
            check("r_id", 64'(r_id), 64'(id));
            check("ar_ready_busy", 64'(ar_ready), 64'd0);
            r_ready = 1'b1;
            @(posedge clk); #1;
            r_ready = 1'b0;
        end
        check("r_valid_fall", 64'(r_valid), 64'd0);
        check("ar_ready_back", 64'(ar_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_ready"}, 64'(aw_ready), 64'd1);
        check({tag, "_ar_ready"}, 64'(ar_ready), 64'd1);
        check({tag, "_w_ready"}, 64'(w_ready), 64'd0);
        check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
        check({tag, "_r_valid"}, 64'(r_valid), 64'd0);
        check({tag, "_r_last"}, 64'(r_last), 64'd0);
        check({tag, "_b_resp"}, 64'(b_resp), 64'd0);
        check({tag, "_r_resp"}, 64'(r_resp), 64'd0);
        check({tag, "_b_id"}, 64'(b_id), 64'd0);
        check({tag, "_r_id"}, 64'(r_id), 64'd0);
    endtask

    initial begin
        aw_valid = 0; aw_id = '0; aw_addr = '0; aw_len = '0;
        w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0; r_ready = 0;
        for (int i = 0; i < int'(NW); i++) model_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write then read.
        wdata[0] = 64'hDEAD_BEEF_0123_4567; wstrb[0] = 8'hFF;
        axi_write(4'd3, 32'h10, 0, -1, 0);
        axi_read(4'd3, 32'h10, 0, -1, 0);

        // Strobed 4-beat burst over a random background.
        for (int k = 0; k < 4; k++) begin
            wdata[k] = {$urandom, $urandom}; wstrb[k] = 8'hFF;
        end
        axi_write(4'd1, 32'h0, 3, -1, 0);
        for (int k = 0; k < 4; k++) begin
            wdata[k] = 64'(k) * 64'h1111; wstrb[k] = 8'h0F;
        end
        axi_write(4'd2, 32'h0, 3, -1, 0);
        axi_read(4'd2, 32'h0, 3, -1, 0);

        // Early w_last, then a clean write.
        wdata[0] = 64'h1; wdata[1] = 64'h2; wstrb[0] = 8'hFF; wstrb[1] = 8'hFF;
        axi_write(4'd5, 32'h20, 1, 0, 0);
        wdata[0] = 64'hABCD;
        axi_write(4'd6, 32'h20, 0, -1, 0);
        axi_read(4'd6, 32'h20, 1, -1, 0);

        // Backpressure on B and R.
        for (int k = 0; k < 4; k++) begin
            wdata[k] = {$urandom, $urandom}; wstrb[k] = 8'hFF;
        end
        axi_write(4'd7, 32'h40, 3, -1, 3);
        axi_read(4'd8, 32'h40, 3, 2, 5);

        // Index 16: aliases onto word 0, or is rejected when checking is on.
        wdata[0] = 64'h5555_AAAA_5555_AAAA; wstrb[0] = 8'hFF;
        axi_write(4'd9, 32'h80, 0, -1, 0);
        axi_read(4'd9, 32'h0, 0, -1, 0);
        axi_read(4'd10, 32'h78, 1, -1, 0);

        // Random traffic, including bursts that cross the top of memory.
        for (int it = 0; it < 24; it++) begin
            logic [AW-1:0] a;
            int            len;
            a   = 32'($urandom_range(0, (NW + 4) * 8 - 1));
            len = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= len; k++) begin
                    wdata[k] = {$urandom, $urandom}; wstrb[k] = 8'($urandom);
                end
                axi_write(4'($urandom), a, len, -1, $urandom_range(0, 2));
            end else begin
                axi_read(4'($urandom), a, len, $urandom_range(0, len), $urandom_range(0, 2));
            end
        end

        // Reset during beat 2 of a 4-beat write.
        aw_valid = 1'b1; aw_id = 4'd9; aw_addr = 32'h0; aw_len = 8'd3;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w_valid = 1'b1; w_data = {$urandom, $urandom}; w_strb = 8'hFF; w_last = 1'b0;
            @(posedge clk); #1;
        end
        w_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        w_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_b_valid", 64'(b_valid), 64'd0);
            check("post_rst_w_ready", 64'(w_ready), 64'd0);
        end
        for (int i = 0; i < int'(NW); i++) model_mem[i] = '0;
        axi_read(4'd0, 32'h0, int'(NW) - 1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
